// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit (1 bit per cycle)
// Shift-add multiply and restoring divide on operand magnitudes; signs fixed on the final value.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LP_LAST = CW'(XLEN);
  localparam logic [XLEN-1:0] LP_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_op;
  logic            r_neg;
  logic [XLEN-1:0] r_b, r_hi, r_lo, r_result;
  logic [CW-1:0]   r_count;

  logic            w_accept, w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_neg_res;
  logic            w_div0, w_ovf, w_special, w_last;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_special_res, w_hi_nxt, w_lo_nxt;
  logic [XLEN-1:0] w_div_sel, w_div_fix, w_final;
  logic [XLEN:0]   w_mul_sum, w_div_trial;
  logic [2*XLEN-1:0] w_prod, w_prod_fix;
  logic [CW-1:0]   w_count_nxt;

  // Request decode: op[2] selects divide, op[0]==0 marks signed divide ops.
  assign w_accept   = req_valid && (r_state == S_IDLE) && !flush;
  assign w_a_signed = op[2] ? ~op[0] : (op[1:0] == 2'd1 || op[1:0] == 2'd2);
  assign w_b_signed = op[2] ? ~op[0] : (op[1:0] == 2'd1);
  assign w_a_neg    = w_a_signed & src_a[XLEN-1];
  assign w_b_neg    = w_b_signed & src_b[XLEN-1];
  assign w_a_mag    = w_a_neg ? -src_a : src_a;
  assign w_b_mag    = w_b_neg ? -src_b : src_b;
  assign w_neg_res  = (op[2] && op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_div0        = op[2] && (src_b == '0);
  assign w_ovf         = op[2] && !op[0] && (src_a == LP_MIN) && (src_b == '1);
  assign w_special     = w_div0 || w_ovf;
  assign w_special_res = w_div0 ? (op[1] ? src_a : '1) : (op[1] ? '0 : LP_MIN);

  // r_hi/r_lo hold accumulator/multiplier for MUL and remainder/dividend-quotient for DIV.
  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_div_trial = {r_hi, r_lo[XLEN-1]} - {1'b0, r_b};

  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_op[2]) begin
      if (!w_div_trial[XLEN]) begin
        w_hi_nxt = w_div_trial[XLEN-1:0];
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_nxt = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      w_hi_nxt = w_mul_sum[XLEN:1];
      w_lo_nxt = {w_mul_sum[0], r_lo[XLEN-1:1]};
    end
  end

  assign w_prod      = {w_hi_nxt, w_lo_nxt};
  assign w_prod_fix  = r_neg ? -w_prod : w_prod;
  assign w_div_sel   = r_op[1] ? w_hi_nxt : w_lo_nxt;
  assign w_div_fix   = r_neg ? -w_div_sel : w_div_sel;
  assign w_final     = r_op[2] ? w_div_fix :
                       (r_op[1:0] == 2'd0) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
  assign w_count_nxt = r_count + 1'b1;
  assign w_last      = (w_count_nxt == LP_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (req_valid) w_state_nxt = w_special ? S_DONE : S_CALC;
        S_CALC:  if (w_last) w_state_nxt = S_DONE;
        S_DONE:  if (resp_ready) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready  = (r_state == S_IDLE);
    busy       = (r_state != S_IDLE);
    resp_valid = (r_state == S_DONE);
    result     = (r_state == S_DONE) ? r_result : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_count  <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op     <= op;
      r_neg    <= w_neg_res;
      r_b      <= w_b_mag;
      r_hi     <= '0;
      r_lo     <= w_a_mag;
      r_count  <= '0;
      r_result <= w_special ? w_special_res : '0;
    end else if (r_state == S_CALC && !flush) begin
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_count <= w_count_nxt;
      if (w_last) r_result <= w_final;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vector bench for muldiv_unit
// Latency counts posedges from the accept edge (inclusive) to the edge after which resp_valid is seen.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, flush, resp_valid, resp_ready, busy;
  logic [2:0]  op;
  logic [31:0] src_a, src_b, result;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .src_a(src_a), .src_b(src_b), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] e, input int l, input string n);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.exp = e; v.lat = l; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    op = 3'($urandom); src_a = $urandom; src_b = $urandom;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    start(v.op, v.a, v.b);
    wait_resp(lat);
    check({v.name, "_result"}, result, v.exp);
    check({v.name, "_latency"}, 32'(lat), 32'(v.lat));
    @(posedge clk);
    #1;
    check({v.name, "_consumed"}, {30'd0, resp_valid, req_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int seen;
    vec_t v;

    rst_n = 1'b0; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b1;
    op = '0; src_a = '0; src_b = '0;

    add(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul_7_x_m3");
    add(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu_max");
    add(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh_min_sq");
    add(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_overflow");
    add(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  "rem_overflow");
    add(3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  "divu_by0");
    add(3'd7, 32'd5,        32'd0,        32'd5,        1,  "remu_by0");
    add(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "rem_m7_2");
    add(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div_m7_2");
    add(3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, "mulhsu_m1_2");
    add(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, "mulh_m1_m1");
    add(3'd5, 32'd100,      32'd7,        32'd14,       33, "divu_100_7");
    add(3'd7, 32'd100,      32'd7,        32'd2,        33, "remu_100_7");
    add(3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, "div_7_m2");
    add(3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        33, "rem_7_m2");
    add(3'd4, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1,  "div_m1_by0");
    add(3'd6, 32'h80000000, 32'd0,        32'h80000000, 1,  "rem_min_by0");
    add(3'd0, 32'h12345678, 32'h10,       32'h23456780, 33, "mul_shift4");
    add(3'd3, 32'h12345678, 32'h10,       32'h00000001, 33, "mulhu_shift4");
    add(3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33, "divu_min_max");

    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready",  {31'd0, req_ready},  32'd1);
    check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset_busy",       {31'd0, busy},       32'd0);
    check("reset_result",     result,              32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      run_vec(v);
    end

    // Consumer stalls in DONE for five cycles
    resp_ready = 1'b0;
    start(3'd0, 32'd3, 32'd5);
    wait_resp(lat);
    check("hold_latency", 32'(lat), 32'd33);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("hold_result",     result,              32'd15);
      check("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_req_ready",  {31'd0, req_ready},  32'd0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_release", {30'd0, resp_valid, req_ready}, 32'd1);

    // Flush at CALC cycle 10
    start(3'd0, 32'h1234, 32'h5678);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_calc_state", {29'd0, busy, resp_valid, req_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen++;
    end
    check("flush_calc_no_resp", 32'(seen), 32'd0);
    v.op = 3'd0; v.a = 32'd3; v.b = 32'd4; v.exp = 32'd12; v.lat = 33; v.name = "post_flush_mul";
    run_vec(v);

    // Request arriving together with flush is dropped
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; op = 3'd5; src_a = 32'd9; src_b = 32'd0;
    @(posedge clk);
    #1;
    req_valid = 1'b0; flush = 1'b0;
    check("flush_drops_req", {29'd0, busy, resp_valid, req_ready}, 32'd1);

    // Flush while holding a response in DONE
    resp_ready = 1'b0;
    start(3'd5, 32'd5, 32'd0);
    check("done_before_flush", {31'd0, resp_valid}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    resp_ready = 1'b1;
    check("flush_done_valid",  {30'd0, resp_valid, req_ready}, 32'd1);
    check("flush_done_result", result, 32'd0);

    // Reset asserted at CALC cycle 5
    start(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_flags",  {29'd0, busy, resp_valid, req_ready}, 32'd1);
    check("midreset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen++;
    end
    check("midreset_no_resp", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
